// File: rtl/bp_me_pkg.sv
// Shared types for the coherence-network reflector.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_refl_req  = 2'b00,
        e_refl_resp = 2'b01
    } bp_refl_op_e;

    typedef enum logic [1:0] {
        e_rx_hdr,
        e_rx_data,
        e_tx_hdr,
        e_tx_data
    } bp_refl_state_e;

    function automatic int unsigned bp_safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_defines.svh
// Header flit layout for reflector packets, LSB first: dest, len, src, op, user.
`ifndef BP_ME_DEFINES_SVH
`define BP_ME_DEFINES_SVH

`define BP_DECLARE_REFL_HDR_S(fw, cw, lw) \
    typedef struct packed { \
        logic [(fw)-2*(cw)-(lw)-3:0] user; \
        logic [1:0]                  op; \
        logic [(cw)-1:0]             src; \
        logic [(lw)-1:0]             len; \
        logic [(cw)-1:0]             dest; \
    } bp_refl_hdr_s

`endif

// File: rtl/bsg_mem_1r1w.sv
// Payload buffer: synchronous write, asynchronous read, no reset.
module bsg_mem_1r1w #(
    parameter int width_p = 64,
    parameter int els_p   = 4,
    parameter int addr_w  = 2
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [addr_w-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [addr_w-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_coh_noc_reflector.sv
// Far-end responder: swallows a request packet and echoes its payload back.
`include "bp_me_defines.svh"

module bp_coh_noc_reflector
    import bp_me_pkg::*;
#(
    parameter int flit_width_p  = 64,
    parameter int cord_width_p  = 8,
    parameter int len_width_p   = 4,
    parameter int max_payload_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic [flit_width_p+1:0] link_i,
    output logic [flit_width_p+1:0] link_o
);

    `BP_DECLARE_REFL_HDR_S(flit_width_p, cord_width_p, len_width_p);

    localparam int addr_w = bp_safe_clog2(max_payload_p);
    localparam logic [len_width_p-1:0] max_len = len_width_p'(max_payload_p);
    localparam logic [len_width_p-1:0] one_len = len_width_p'(1);

    bp_refl_state_e state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    bp_refl_hdr_s hdr_q, hdr_d;
    logic rdy_q, rdy_d;
    logic v_q, v_d;

    logic in_v, out_rdy, in_fire, out_fire;
    logic [flit_width_p-1:0] in_data, rdata, data_o;
    bp_refl_hdr_s hdr_in, resp_hdr;
    logic [len_width_p-1:0] resp_len;
    logic buf_we;

    assign in_v    = link_i[flit_width_p+1];
    assign in_data = link_i[flit_width_p:1];
    assign out_rdy = link_i[0];
    assign hdr_in  = in_data;

    assign in_fire  = rdy_q & in_v;
    assign out_fire = v_q & out_rdy;
    assign resp_len = (hdr_q.len > max_len) ? max_len : hdr_q.len;

    always_comb begin
        resp_hdr      = hdr_q;
        resp_hdr.dest = hdr_q.src;
        resp_hdr.src  = my_cord_i;
        resp_hdr.len  = resp_len;
        resp_hdr.op   = hdr_q.op ^ e_refl_resp;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        buf_we  = 1'b0;
        unique case (state_q)
            e_rx_hdr: if (in_fire) begin
                hdr_d   = hdr_in;
                cnt_d   = '0;
                state_d = (hdr_in.len == '0) ? e_tx_hdr : e_rx_data;
            end
            e_rx_data: if (in_fire) begin
                buf_we = (cnt_q < max_len);
                if (cnt_q == hdr_q.len - one_len) begin
                    cnt_d   = '0;
                    state_d = e_tx_hdr;
                end else begin
                    cnt_d = cnt_q + one_len;
                end
            end
            e_tx_hdr: if (out_fire) begin
                cnt_d   = '0;
                state_d = (resp_len == '0) ? e_rx_hdr : e_tx_data;
            end
            e_tx_data: if (out_fire) begin
                if (cnt_q == resp_len - one_len) begin
                    cnt_d   = '0;
                    state_d = e_rx_hdr;
                end else begin
                    cnt_d = cnt_q + one_len;
                end
            end
            default: state_d = e_rx_hdr;
        endcase
        // Handshake outputs are registered copies of the next state's phase.
        rdy_d = (state_d == e_rx_hdr) || (state_d == e_rx_data);
        v_d   = (state_d == e_tx_hdr) || (state_d == e_tx_data);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_rx_hdr;
            cnt_q   <= '0;
            hdr_q   <= '0;
            rdy_q   <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            rdy_q   <= rdy_d;
            v_q     <= v_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p (flit_width_p),
        .els_p   (max_payload_p),
        .addr_w  (addr_w)
    ) payload_buf (
        .clk_i    (clk_i),
        .w_v_i    (buf_we),
        .w_addr_i (cnt_q[addr_w-1:0]),
        .w_data_i (in_data),
        .r_addr_i (cnt_q[addr_w-1:0]),
        .r_data_o (rdata)
    );

    always_comb begin
        data_o = '0;
        unique case (state_q)
            e_tx_hdr:  data_o = resp_hdr;
            e_tx_data: data_o = rdata;
            default:   data_o = '0;
        endcase
    end

    assign link_o = {v_q, data_o, rdy_q};

endmodule

// File: tb/tb_bp_coh_noc_reflector.sv
// Randomized bench for the reflector against a packet-level reference model.
module tb_bp_coh_noc_reflector;

    localparam int W = 64;
    localparam int C = 8;
    localparam int L = 4;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [C-1:0] my_cord = 8'h5A;
    logic [W+1:0] link_i, link_o;
    logic in_v = 1'b0;
    logic [W-1:0] in_d = '0;
    logic out_rdy = 1'b0;

    assign link_i = {in_v, in_d, out_rdy};

    bp_coh_noc_reflector #(
        .flit_width_p  (W),
        .cord_width_p  (C),
        .len_width_p   (L),
        .max_payload_p (P)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .my_cord_i (my_cord),
        .link_i    (link_i),
        .link_o    (link_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           last;
    } flit_t;

    flit_t        tx_q[$];
    logic [W-1:0] resp_q[$];
    int           resp_n_q[$];
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;
    int gap_pct  = 0;
    int stall_at = 0;
    int stall_left = 0;

    task automatic check(input string tag, input logic [W+1:0] obs,
                         input logic [W+1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_hdr(input int dest, input int len,
                                            input int src, input int op,
                                            input logic [63:0] user);
        logic [W-1:0] h;
        h = (user << (2*C+L+2))
          | (64'(op & 3) << (2*C+L))
          | (64'(src & 255) << (C+L))
          | (64'(len & 15) << C)
          | 64'(dest & 255);
        return h;
    endfunction

    // Queue a request; only a fully sent one earns a modelled response.
    task automatic queue_req(input int len, input int send_n,
                             input int src, input int op);
        logic [63:0] r;
        logic [63:0] user;
        logic [W-1:0] pay[$];
        int rl;
        flit_t f;
        r = {$urandom, $urandom};
        user = r & ((64'd1 << (W-2*C-L-2)) - 1);
        f.d = mk_hdr($urandom_range(255), len, src, op, user);
        f.last = (len == 0) && (send_n == len);
        tx_q.push_back(f);
        for (int i = 0; i < send_n; i++) begin
            pay.push_back({$urandom, $urandom});
            f.d = pay[i];
            f.last = (i == len - 1) && (send_n == len);
            tx_q.push_back(f);
        end
        if (send_n == len) begin
            rl = (len > P) ? P : len;
            resp_q.push_back(mk_hdr(src, rl, int'(my_cord), op ^ 1, user));
            for (int i = 0; i < rl; i++) resp_q.push_back(pay[i]);
            resp_n_q.push_back(rl + 1);
        end
    endtask

    task automatic run(input int budget);
        int cyc = 0;
        int out_idx = 0;
        bit v, rdy, pv, prdy, in_x, out_x;
        logic [W-1:0] d, pd;
        flit_t f;
        int n;
        pv = 0; prdy = 1; pd = '0;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            v   = link_o[W+1];
            rdy = link_o[0];
            d   = link_o[W:1];
            check("v_phase", {65'd0, v}, {65'd0, exp_q.size() != 0});
            check("rdy_phase", {65'd0, rdy}, {65'd0, exp_q.size() == 0});
            if (pv && !prdy && v) check("hold_data", {2'b0, d}, {2'b0, pd});
            in_v = (tx_q.size() != 0) && ($urandom_range(99) >= gap_pct);
            in_d = in_v ? tx_q[0].d : {$urandom, $urandom};
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ($urandom_range(99) < 70);
                default: begin
                    out_rdy = 1'b1;
                    if (v && out_idx == stall_at && stall_left > 0) begin
                        out_rdy = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            in_x  = in_v && rdy;
            out_x = v && out_rdy;
            if (out_x) begin
                check("resp_flit", {2'b0, d}, {2'b0, exp_q.pop_front()});
                out_idx++;
            end
            if (in_x) begin
                f = tx_q.pop_front();
                if (f.last) begin
                    n = resp_n_q.pop_front();
                    repeat (n) exp_q.push_back(resp_q.pop_front());
                    out_idx = 0;
                end
            end
            pv = v; prdy = out_rdy; pd = d;
            @(posedge clk); #1;
            cyc++;
        end
        in_v = 1'b0;
        out_rdy = 1'b0;
        check("run_done", {65'd0, tx_q.size() == 0 && exp_q.size() == 0}, 66'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, link_o, '0);
    endtask

    task automatic pulse_reset();
        in_v = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;
        check("rdy_before_edge", {65'd0, link_o[0]}, 66'd0);
        @(posedge clk); #1;
        check("rdy_first_edge", {65'd0, link_o[0]}, 66'd1);
        check("v_after_reset", {65'd0, link_o[W+1]}, 66'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        check_reset_outputs("reset_state_edge");
        rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_init", {65'd0, link_o[0]}, 66'd1);

        // Zero-length request.
        rdy_mode = 0; gap_pct = 0;
        queue_req(0, 0, 8'h12, 0);
        run(200);

        // Four-flit request, sink always ready.
        queue_req(4, 4, $urandom_range(255), 0);
        run(200);

        // Oversized request is truncated in the response.
        queue_req(7, 7, $urandom_range(255), 0);
        run(200);

        // Sink stalls three cycles mid-payload.
        rdy_mode = 2; stall_at = 2; stall_left = 3;
        queue_req(4, 4, $urandom_range(255), 0);
        run(200);
        check("stall_used", 66'(stall_left), 66'd0);

        // Reset after two of four payload flits.
        rdy_mode = 0;
        queue_req(4, 2, $urandom_range(255), 0);
        run(200);
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            check("v_quiet", {65'd0, link_o[W+1]}, 66'd0);
            @(posedge clk); #1;
        end
        queue_req(4, 4, $urandom_range(255), 0);
        run(200);

        // Next request waiting while a response drains.
        rdy_mode = 1;
        queue_req(3, 3, $urandom_range(255), 2);
        queue_req(15, 15, $urandom_range(255), 1);
        run(400);

        // Randomized traffic.
        gap_pct = 20;
        for (int i = 0; i < 25; i++) begin
            int ln;
            ln = $urandom_range(15);
            queue_req(ln, ln, $urandom_range(255), $urandom_range(3));
        end
        run(5000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
